reg_nbits_universal: RTL and testbench

//  N-bit universal register: parallel load, hold, clear, logical/arithmetic shift and rotate.

---
 rtl/reg_nbits_universal.sv | 149 ++++++++++++++
 tb/tb_reg_nbits_universal.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_nbits_universal.sv
// rtl/reg_nbits_universal.sv - N-bit universal register with multi-cycle shift sequencer
module reg_nbits_universal #(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
) (
  input  logic          reloj,
  input  logic          reset,
  input  logic [2:0]    modo,
  input  logic [N-1:0]  In,
  input  logic          serial_izq,
  input  logic          serial_der,
  input  logic          inicio,
  input  logic [CW-1:0] cuenta,
  output logic [N-1:0]  An,
  output logic          s_msb,
  output logic          s_lsb,
  output logic          cero,
  output logic          ocupado,
  output logic          listo
);

  // Operation encodings on 'modo'
  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  // Largest useful count: a rotate by N is a full cycle, a shift by N empties the register
  localparam logic [CW-1:0] COUNT_MAX = CW'(N);
  localparam logic [CW-1:0] COUNT_ONE = CW'(1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t        state_q;
  logic [N-1:0]  an_q;
  logic [2:0]    mode_q;
  logic [CW-1:0] rem_q;
  logic          ocupado_q;
  logic          listo_q;

  logic [2:0]    op_sel_d;
  logic [N-1:0]  an_next_d;
  logic [CW-1:0] count_d;
  logic          start_shift_d;

  // Single-step result of one operation applied to the current register value
  function automatic logic [N-1:0] apply_op(
    input logic [2:0]   op,
    input logic [N-1:0] cur,
    input logic [N-1:0] din,
    input logic         sl,
    input logic         sr
  );
    logic [N-1:0] r;
    r = cur;
    case (op)
      M_HOLD: r = cur;
      M_LOAD: r = din;
      M_SHL:  r = {cur[N-2:0], sr};
      M_SHR:  r = {sl, cur[N-1:1]};
      M_ROL:  r = {cur[N-2:0], cur[N-1]};
      M_ROR:  r = {cur[0], cur[N-1:1]};
      M_ASR:  r = {cur[N-1], cur[N-1:1]};
      M_CLR:  r = '0;
      default: r = cur;
    endcase
    return r;
  endfunction

  // Only the five shift/rotate modes can be run as a multi-cycle sequence
  function automatic logic is_shift_mode(input logic [2:0] op);
    return (op != M_HOLD) && (op != M_LOAD) && (op != M_CLR);
  endfunction

  // Pick the operation for this edge (latched mode while shifting) and clamp the count
  always_comb begin
    op_sel_d      = (state_q == ST_SHIFT) ? mode_q : modo;
    an_next_d     = apply_op(op_sel_d, an_q, In, serial_izq, serial_der);
    count_d       = (cuenta > COUNT_MAX) ? COUNT_MAX : cuenta;
    start_shift_d = inicio && is_shift_mode(modo);
  end

  // Register, shift sequencer and handshake outputs
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      an_q      <= '0;
      mode_q    <= M_HOLD;
      rem_q     <= '0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
    end else begin
      listo_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_shift_d) begin
            if (cuenta == '0) begin
              // Zero-length sequence completes immediately without touching An
              listo_q <= 1'b1;
            end else begin
              mode_q    <= modo;
              rem_q     <= count_d;
              ocupado_q <= 1'b1;
              state_q   <= ST_SHIFT;
            end
          end else begin
            an_q <= an_next_d;
          end
        end
        ST_SHIFT: begin
          if (modo == M_CLR) begin
            // Abort: clear wins over the pending step and no completion is reported
            an_q      <= '0;
            rem_q     <= '0;
            ocupado_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            an_q  <= an_next_d;
            rem_q <= rem_q - COUNT_ONE;
            if (rem_q == COUNT_ONE) begin
              ocupado_q <= 1'b0;
              listo_q   <= 1'b1;
              state_q   <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign An      = an_q;
  assign s_msb   = an_q[N-1];
  assign s_lsb   = an_q[0];
  assign cero    = (an_q == '0);
  assign ocupado = ocupado_q;
  assign listo   = listo_q;

endmodule

// File: tb/tb_reg_nbits_universal.sv
// tb/tb_reg_nbits_universal.sv - directed table and sequence bench for reg_nbits_universal
module tb_reg_nbits_universal;

  localparam int N  = 8;
  localparam int CW = 4;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic          reloj = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    modo = M_HOLD;
  logic [N-1:0]  In = '0;
  logic          serial_izq = 1'b0;
  logic          serial_der = 1'b0;
  logic          inicio = 1'b0;
  logic [CW-1:0] cuenta = '0;
  logic [N-1:0]  An;
  logic          s_msb, s_lsb, cero, ocupado, listo;

  int errors = 0;
  int checks = 0;

  reg_nbits_universal #(.N(N), .CW(CW)) dut (
    .reloj(reloj), .reset(reset), .modo(modo), .In(In),
    .serial_izq(serial_izq), .serial_der(serial_der),
    .inicio(inicio), .cuenta(cuenta),
    .An(An), .s_msb(s_msb), .s_lsb(s_lsb), .cero(cero),
    .ocupado(ocupado), .listo(listo)
  );

  always #5 reloj = ~reloj;

  typedef struct {
    logic [2:0] modo;
    logic       inicio;
    logic [7:0] din;
    logic       sl;
    logic       sd;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] an_e, input logic oc_e, input logic li_e);
    chk({tag, " An"}, 32'(An), 32'(an_e));
    chk({tag, " s_msb"}, 32'(s_msb), 32'(an_e[7]));
    chk({tag, " s_lsb"}, 32'(s_lsb), 32'(an_e[0]));
    chk({tag, " cero"}, 32'(cero), 32'(an_e == 8'h00));
    chk({tag, " ocupado"}, 32'(ocupado), 32'(oc_e));
    chk({tag, " listo"}, 32'(listo), 32'(li_e));
  endtask

  task automatic tick;
    @(posedge reloj);
    @(negedge reloj);
  endtask

  task automatic drive(input logic [2:0] m, input logic st, input logic [7:0] d, input logic [3:0] c);
    modo   = m;
    inicio = st;
    In     = d;
    cuenta = c;
  endtask

  function automatic vec_t mk(input logic [2:0] m, input logic st, input logic [7:0] d,
                              input logic sl, input logic sd, input logic [7:0] e);
    vec_t v;
    v.modo = m; v.inicio = st; v.din = d; v.sl = sl; v.sd = sd; v.exp = e;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[19];
    logic [7:0] e4[3];
    logic [7:0] e6[8];

    vecs[0]  = mk(M_LOAD, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5);
    vecs[1]  = mk(M_HOLD, 1'b0, 8'hFF, 1'b0, 1'b0, 8'hA5);
    vecs[2]  = mk(M_HOLD, 1'b1, 8'hFF, 1'b0, 1'b0, 8'hA5);
    vecs[3]  = mk(M_HOLD, 1'b0, 8'hFF, 1'b0, 1'b0, 8'hA5);
    vecs[4]  = mk(M_CLR,  1'b0, 8'hFF, 1'b0, 1'b0, 8'h00);
    vecs[5]  = mk(M_LOAD, 1'b1, 8'hA5, 1'b0, 1'b0, 8'hA5);
    vecs[6]  = mk(M_SHL,  1'b0, 8'hFF, 1'b0, 1'b1, 8'h4B);
    vecs[7]  = mk(M_LOAD, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5);
    vecs[8]  = mk(M_SHR,  1'b0, 8'hFF, 1'b0, 1'b1, 8'h52);
    vecs[9]  = mk(M_LOAD, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5);
    vecs[10] = mk(M_ASR,  1'b0, 8'hFF, 1'b0, 1'b0, 8'hD2);
    vecs[11] = mk(M_LOAD, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5);
    vecs[12] = mk(M_ROR,  1'b0, 8'hFF, 1'b0, 1'b0, 8'hD2);
    vecs[13] = mk(M_LOAD, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5);
    vecs[14] = mk(M_ROL,  1'b0, 8'hFF, 1'b0, 1'b0, 8'h4B);
    vecs[15] = mk(M_SHR,  1'b0, 8'hFF, 1'b1, 1'b0, 8'hA5);
    vecs[16] = mk(M_SHL,  1'b0, 8'hFF, 1'b1, 1'b0, 8'h4A);
    vecs[17] = mk(M_ASR,  1'b0, 8'hFF, 1'b0, 1'b0, 8'h25);
    vecs[18] = mk(M_CLR,  1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);

    e4 = '{8'h03, 8'h06, 8'h0C};
    e6 = '{8'h1E, 8'h0F, 8'h87, 8'hC3, 8'hE1, 8'hF0, 8'h78, 8'h3C};

    // Power-on reset
    tick;
    tick;
    chk_state("por", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;

    // Reset asserted between edges in the middle of a shift sequence
    drive(M_LOAD, 1'b0, 8'hFF, 4'd0);
    tick;
    chk_state("rst load", 8'hFF, 1'b0, 1'b0);
    serial_der = 1'b0;
    drive(M_SHL, 1'b1, 8'h00, 4'd8);
    tick;
    chk_state("rst accept", 8'hFF, 1'b1, 1'b0);
    drive(M_HOLD, 1'b0, 8'h00, 4'd0);
    tick;
    chk_state("rst shift1", 8'hFE, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 chk_state("rst async", 8'h00, 1'b0, 1'b0);
    @(negedge reloj);
    reset = 1'b0;
    tick;
    chk_state("rst after1", 8'h00, 1'b0, 1'b0);
    tick;
    chk_state("rst after2", 8'h00, 1'b0, 1'b0);

    // Single-cycle operation table
    for (int i = 0; i < 19; i++) begin
      modo       = vecs[i].modo;
      inicio     = vecs[i].inicio;
      In         = vecs[i].din;
      serial_izq = vecs[i].sl;
      serial_der = vecs[i].sd;
      cuenta     = 4'd0;
      tick;
      chk_state($sformatf("vec%0d", i), vecs[i].exp, 1'b0, 1'b0);
    end
    serial_izq = 1'b0;
    serial_der = 1'b0;

    // ROL by 3 from 81, then back-to-back start in the listo cycle
    drive(M_LOAD, 1'b0, 8'h81, 4'd0);
    tick;
    chk_state("rol load", 8'h81, 1'b0, 1'b0);
    drive(M_ROL, 1'b1, 8'h00, 4'd3);
    tick;
    chk_state("rol accept", 8'h81, 1'b1, 1'b0);
    drive(M_LOAD, 1'b0, 8'h00, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_state($sformatf("rol step%0d", i), e4[i], (i < 2), (i == 2));
    end
    drive(M_ROL, 1'b1, 8'h00, 4'd1);
    tick;
    chk_state("b2b accept", 8'h0C, 1'b1, 1'b0);
    drive(M_HOLD, 1'b0, 8'h00, 4'd0);
    tick;
    chk_state("b2b done", 8'h18, 1'b0, 1'b1);
    tick;
    chk_state("b2b after", 8'h18, 1'b0, 1'b0);

    // ASR by 5 from 80, aborted by CLR after two steps
    drive(M_LOAD, 1'b0, 8'h80, 4'd0);
    tick;
    drive(M_ASR, 1'b1, 8'h00, 4'd5);
    tick;
    chk_state("asr accept", 8'h80, 1'b1, 1'b0);
    drive(M_HOLD, 1'b0, 8'h00, 4'd0);
    tick;
    chk_state("asr step0", 8'hC0, 1'b1, 1'b0);
    tick;
    chk_state("asr step1", 8'hE0, 1'b1, 1'b0);
    drive(M_CLR, 1'b0, 8'h00, 4'd0);
    tick;
    chk_state("asr abort", 8'h00, 1'b0, 1'b0);
    drive(M_HOLD, 1'b0, 8'h00, 4'd0);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk_state($sformatf("abort idle%0d", i), 8'h00, 1'b0, 1'b0);
    end

    // ROR with count 12 clamps to 8 and restores the value; then count 0
    drive(M_LOAD, 1'b0, 8'h3C, 4'd0);
    tick;
    drive(M_ROR, 1'b1, 8'h00, 4'd12);
    tick;
    chk_state("ror accept", 8'h3C, 1'b1, 1'b0);
    drive(M_HOLD, 1'b0, 8'hFF, 4'd0);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk_state($sformatf("ror step%0d", i), e6[i], (i < 7), (i == 7));
    end
    drive(M_ROR, 1'b1, 8'h00, 4'd0);
    tick;
    chk_state("cnt0 done", 8'h3C, 1'b0, 1'b1);
    drive(M_HOLD, 1'b0, 8'h00, 4'd0);
    tick;
    chk_state("cnt0 after", 8'h3C, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
